// File: rtl/apb_pkg.sv
// Shared APB widths, completer FSM states and the register address decoder.
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_cmp_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] index;
    logic                  err;
  } apb_dec_t;

  // err covers misalignment and out-of-range only; read-only checks need the mask
  function automatic apb_dec_t apb_decode(input logic [ADDR_WIDTH-1:0] addr,
                                          input int unsigned           num_regs);
    apb_dec_t d;
    d.index = (addr >> 2) & ADDR_WIDTH'(num_regs - 1);
    d.err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= ADDR_WIDTH'(num_regs));
    return d;
  endfunction

endpackage

// File: rtl/apb_cmp_fsm.sv
// APB completer handshake: state, wait-state counter, pready and abort handling.
module apb_cmp_fsm #(
  parameter int WAIT_STATES = 1
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic accept,
  output logic load_rsp,
  output logic complete
);
  import apb_pkg::*;

  apb_cmp_state_e state;
  apb_cmp_state_e nxt;
  logic [3:0]     cnt;

  // psel+penable straight from IDLE skips the wait states and goes to DONE
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (psel) nxt = (penable || WAIT_STATES == 0) ? DONE : WAIT;
      WAIT:    if (!psel) nxt = IDLE; else if (cnt == 4'd1) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  assign accept   = (state == IDLE) && psel;
  assign load_rsp = (nxt == DONE);
  assign complete = (state == DONE) && psel && penable;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state  <= IDLE;
      cnt    <= '0;
      pready <= 1'b0;
    end else begin
      state  <= nxt;
      pready <= (nxt == DONE);
      if (state == IDLE)
        cnt <= 4'(WAIT_STATES);
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer for a bank of R/W control and hardware-driven read-only status registers.
module apb_reg_completer #(
  parameter int                  ADDR_WIDTH  = apb_pkg::ADDR_WIDTH,
  parameter int                  DATA_WIDTH  = apb_pkg::DATA_WIDTH,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = 16'hFF00
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  import apb_pkg::*;

  localparam int IW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] ro_w [NUM_REGS];

  apb_dec_t              dec_now;
  logic [IW-1:0]         idx_now, cap_idx, sel_idx;
  logic                  err_now, cap_err, sel_err;
  logic                  cap_write, sel_write;
  logic [DATA_WIDTH-1:0] cap_wdata, rdata;
  logic                  accept, load_rsp, complete;

  apb_cmp_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .accept  (accept),
    .load_rsp(load_rsp),
    .complete(complete)
  );

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
      ro_w[i] = ro_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // With no wait states (or a protocol violation) the response is built from the
  // live bus in the same cycle it is accepted, otherwise from the captured copy.
  always_comb begin
    dec_now   = apb_decode(paddr, NUM_REGS);
    idx_now   = dec_now.index[IW-1:0];
    err_now   = dec_now.err || penable || (pwrite && RO_MASK[idx_now]);
    sel_idx   = accept ? idx_now : cap_idx;
    sel_err   = accept ? err_now : cap_err;
    sel_write = accept ? pwrite  : cap_write;
    rdata     = RO_MASK[sel_idx] ? ro_w[sel_idx] : regs[sel_idx];
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      cap_idx    <= '0;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      cap_err    <= 1'b0;
      prdata     <= '0;
      pslverr    <= 1'b0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (accept) begin
        cap_idx   <= idx_now;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
        cap_err   <= err_now;
      end
      if (load_rsp) begin
        pslverr <= sel_err;
        prdata  <= (sel_err || sel_write) ? '0 : rdata;
      end else begin
        pslverr <= 1'b0;
        prdata  <= '0;
      end
      if (complete && cap_write && !cap_err) begin
        regs[cap_idx]       <= cap_wdata;
        wr_pulse_o[cap_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: two instances (0 and 1 wait states) checked every cycle against a transaction-level model.
module tb_apb_reg_completer;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam int FW = NR * DW;
  localparam logic [15:0] ROM = 16'hFF00;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic          preset   [2];
  logic          psel     [2];
  logic          penable  [2];
  logic          pwrite   [2];
  logic [31:0]   paddr    [2];
  logic [31:0]   pwdata   [2];
  logic [31:0]   prdata   [2];
  logic          pready   [2];
  logic          pslverr  [2];
  logic [FW-1:0] regs_o   [2];
  logic [15:0]   wr_pulse [2];
  logic [FW-1:0] ro_i;

  apb_reg_completer #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset[0]), .paddr(paddr[0]), .psel(psel[0]),
    .penable(penable[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .regs_o(regs_o[0]), .ro_i(ro_i), .wr_pulse_o(wr_pulse[0])
  );

  apb_reg_completer #(.WAIT_STATES(1)) dut1 (
    .pclk(pclk), .preset(preset[1]), .paddr(paddr[1]), .psel(psel[1]),
    .penable(penable[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .regs_o(regs_o[1]), .ro_i(ro_i), .wr_pulse_o(wr_pulse[1])
  );

  // model state: expected outputs for the current cycle, plus a write due at the next edge
  logic [FW-1:0] m_regs      [2];
  logic          exp_pready  [2];
  logic          exp_pslverr [2];
  logic [31:0]   exp_prdata  [2];
  logic [15:0]   exp_pulse   [2];
  logic          pend_v      [2];
  int            pend_idx    [2];
  logic [31:0]   pend_data   [2];

  logic [31:0] last_rdata [2];
  logic        last_err   [2];
  logic [15:0] last_pulse [2];

  int checks = 0;
  int errors = 0;
  int last_d = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pready%0d", d),  64'(pready[d]),   64'(exp_pready[d]));
      chk($sformatf("pslverr%0d", d), 64'(pslverr[d]),  64'(exp_pslverr[d]));
      chk($sformatf("prdata%0d", d),  64'(prdata[d]),   64'(exp_prdata[d]));
      chk($sformatf("wr_pulse%0d", d), 64'(wr_pulse[d]), 64'(exp_pulse[d]));
      checks++;
      if (regs_o[d] !== m_regs[d]) begin
        errors++;
        $display("FAIL regs_o%0d: got %h expected %h", d, regs_o[d], m_regs[d]);
      end
      if (pready[d]) begin
        last_rdata[d] = prdata[d];
        last_err[d]   = pslverr[d];
      end
      if (wr_pulse[d] != 16'h0) last_pulse[d] = wr_pulse[d];
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_pready[d]  = 1'b0;
      exp_pslverr[d] = 1'b0;
      exp_prdata[d]  = '0;
      exp_pulse[d]   = '0;
      if (pend_v[d]) begin
        m_regs[d][pend_idx[d]*DW +: DW] = pend_data[d];
        exp_pulse[d][pend_idx[d]] = 1'b1;
        pend_v[d] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    step();
    for (int d = 0; d < 2; d++) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
    end
  endtask

  // One full transfer on instance d (d also equals its wait-state count).
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit abort);
    int          idx;
    bit          err;
    logic [31:0] rd;
    step();
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    idx = int'(addr[5:2]);
    err = (addr[1:0] != 2'b00) || (addr >= 32'd64) || (wr && ROM[idx]);
    if (err || wr)    rd = '0;
    else if (ROM[idx]) rd = ro_i[idx*DW +: DW];
    else               rd = m_regs[d][idx*DW +: DW];
    for (int k = 0; k < d; k++) begin
      step();
      penable[d] = 1'b1; pwrite[d] = 1'($urandom); paddr[d] = $urandom; pwdata[d] = $urandom;
      if (abort) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        return;
      end
    end
    step();
    exp_pready[d] = 1'b1; exp_pslverr[d] = err; exp_prdata[d] = rd;
    if (wr && !err) begin
      pend_v[d] = 1'b1; pend_idx[d] = idx; pend_data[d] = wdata;
    end
    penable[d] = 1'b1; pwrite[d] = 1'($urandom); paddr[d] = $urandom; pwdata[d] = $urandom;
  endtask

  task automatic viol(input int d);
    step();
    psel[d] = 1'b1; penable[d] = 1'b1; paddr[d] = 32'h4; pwrite[d] = 1'b1; pwdata[d] = $urandom;
    step();
    exp_pready[d] = 1'b1; exp_pslverr[d] = 1'b1; exp_prdata[d] = '0;
  endtask

  task automatic reset_mid(input int d);
    step();
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = 32'h10; pwdata[d] = 32'hCAFE0001;
    for (int k = 0; k < d; k++) begin
      step();
      penable[d] = 1'b1;
    end
    step();
    exp_pready[d] = 1'b1;
    #2;
    preset[d] = 1'b1;
    exp_pready[d] = 1'b0;
    m_regs[d] = '0;
    #1;
    chk("rst_pready", 64'(pready[d]), 64'h0);
    chk("rst_prdata", 64'(prdata[d]), 64'h0);
    chk("rst_reg4", 64'(regs_o[d][4*DW +: DW]), 64'h0);
    step();
    preset[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
      m_regs[d] = '0; exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0;
      exp_prdata[d] = '0; exp_pulse[d] = '0; pend_v[d] = 1'b0; pend_idx[d] = 0; pend_data[d] = '0;
      last_rdata[d] = '0; last_err[d] = 1'b0; last_pulse[d] = '0;
    end
    for (int i = 0; i < NR; i++) ro_i[i*DW +: DW] = $urandom;
    ro_i[8*DW +: DW] = 32'h12345678;

    step();
    chk("reset_pready", 64'(pready[1]), 64'h0);
    chk("reset_pslverr", 64'(pslverr[1]), 64'h0);
    chk("reset_prdata", 64'(prdata[1]), 64'h0);
    chk("reset_pulse", 64'(wr_pulse[1]), 64'h0);
    preset[0] = 1'b0; preset[1] = 1'b0;

    xfer(1, 1'b1, 32'h04, 32'hDEADBEEF, 1'b0);
    idle(); idle();
    chk("wr_reg1", 64'(regs_o[1][1*DW +: DW]), 64'hDEADBEEF);
    chk("wr_err", 64'(last_err[1]), 64'h0);
    chk("wr_pulse", 64'(last_pulse[1]), 64'h0002);

    xfer(1, 1'b0, 32'h04, 32'h0, 1'b0);
    idle(); idle();
    chk("rd_reg1", 64'(last_rdata[1]), 64'hDEADBEEF);
    xfer(1, 1'b0, 32'h20, 32'h0, 1'b0);
    idle(); idle();
    chk("rd_ro8", 64'(last_rdata[1]), 64'h12345678);

    xfer(1, 1'b1, 32'h20, 32'h11111111, 1'b0); idle(); idle();
    chk("wr_ro_err", 64'(last_err[1]), 64'h1);
    xfer(1, 1'b1, 32'h41, 32'h22222222, 1'b0); idle(); idle();
    chk("wr_misalign_err", 64'(last_err[1]), 64'h1);
    last_err[1] = 1'b0;
    xfer(1, 1'b1, 32'h40, 32'h33333333, 1'b0); idle(); idle();
    chk("wr_oor_err", 64'(last_err[1]), 64'h1);
    chk("reg1_kept", 64'(regs_o[1][1*DW +: DW]), 64'hDEADBEEF);

    xfer(0, 1'b1, 32'h00, 32'hA5A5A5A5, 1'b0);
    xfer(0, 1'b1, 32'h08, 32'h5A5A5A5A, 1'b0);
    idle(); idle();
    chk("b2b_reg0", 64'(regs_o[0][0 +: DW]), 64'hA5A5A5A5);
    chk("b2b_reg2", 64'(regs_o[0][2*DW +: DW]), 64'h5A5A5A5A);

    xfer(1, 1'b1, 32'h0C, 32'h77777777, 1'b1);
    idle(); idle();
    chk("abort_reg3", 64'(regs_o[1][3*DW +: DW]), 64'h0);
    xfer(1, 1'b1, 32'h0C, 32'h88888888, 1'b0);
    idle(); idle();
    chk("after_abort_reg3", 64'(regs_o[1][3*DW +: DW]), 64'h88888888);

    last_err[1] = 1'b0;
    viol(1); idle(); idle();
    chk("viol_err", 64'(last_err[1]), 64'h1);

    reset_mid(1);
    reset_mid(0);
    idle();

    last_d = 0;
    for (int n = 0; n < 300; n++) begin
      int          d, r, s;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      if (d != last_d) idle();
      last_d = d;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        viol(d); idle();
      end else if (r < 12) begin
        idle();
        ro_i[$urandom_range(0, NR-1)*DW +: DW] = $urandom;
      end else begin
        s = int'($urandom_range(0, 9));
        if (s < 7)       a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        else if (s == 7) a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
        else if (s == 8) a = 32'd64 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        else             a = $urandom;
        xfer(d, 1'($urandom), a, $urandom, (d == 1) && ($urandom_range(0, 9) == 0));
        if ($urandom_range(0, 1) == 0) idle();
      end
    end
    idle(); idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_reg_completer.md
Name: apb_reg_completer

Overview:
- APB completer (peripheral end of the APB bus): a bank of NUM_REGS word-wide registers behind APB, with a configurable wait-state count.
- Some registers are software read/write control registers. The rest are read-only status words driven by hardware.
- Decodes, accepts and responds to requester transfers, including error responses.
- Sits behind the APB interconnect and drives the peripheral side of the APB interface.

Parameters:
- ADDR_WIDTH, 32 (apb_pkg::ADDR_WIDTH): paddr width.
- DATA_WIDTH, 32 (apb_pkg::DATA_WIDTH): pwdata/prdata width.
- NUM_REGS, 16: register count, power of two, at least 2.
- WAIT_STATES, 1: pready low for this many access-phase cycles before completion; range 0..15.
- RO_MASK, 16'hFF00: bit i set means register i is read-only; its read value comes from ro_i.

Ports:
- pclk  in  1  APB clock; all logic on its rising edge.
- preset  in  1  asynchronous, active-high reset.
- paddr  in  ADDR_WIDTH  byte address.
- psel  in  1  peripheral select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1=write, 0=read.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data; valid only in the completion cycle.
- pready  out  1  transfer completion.
- pslverr  out  1  error response; valid only with pready.
- regs_o  out  NUM_REGS*DATA_WIDTH  flattened R/W register contents; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- ro_i  in  NUM_REGS*DATA_WIDTH  hardware values for read-only registers; slices at non-RO indices are ignored.
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on bit i when register i is written.

Behaviour:
- Reset (async assert, sync-safe release): FSM goes to IDLE. pready=0, pslverr=0, prdata=0, wr_pulse_o=0, all R/W registers=0.
- All APB outputs are registered.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On psel & !penable (setup phase): capture paddr, pwrite and pwdata, and compute err.
  - Next state is DONE if WAIT_STATES==0, otherwise WAIT with cnt=WAIT_STATES.
- WAIT: cnt decrements each cycle; when cnt==1, next state is DONE. pready=0 throughout.
- DONE:
  - pready=1 and pslverr=err.
  - prdata = read data, or 0 if the transfer is a write or err=1.
  - Next state is always IDLE. Back-to-back setup in the following cycle is accepted, so the minimum transfer is 2 cycles (setup + access).
- Latency: the access phase lasts WAIT_STATES+1 cycles, with pready high in the last of them.
- Decode:
  - Register index = paddr[2 +: $clog2(NUM_REGS)].
  - err=1 if paddr[1:0]!=0, or paddr >= NUM_REGS*4, or (write and RO_MASK[index]).
- Read data:
  - R/W register: register value.
  - RO register: ro_i slice sampled on the clock edge entering DONE.
- Write commit:
  - Occurs at the DONE clock edge when psel & penable are high and err=0.
  - The register updates, and wr_pulse_o[index]=1 for the following single cycle.
  - An erroring write leaves all registers unchanged.
- psel deasserted while in WAIT or DONE: abort. Return to IDLE, pready=0, no write, no pulse.
- psel & penable seen in IDLE (protocol violation, no setup): treat as an erroring transfer. Go to DONE with err=1, no write.
- pwrite, paddr or pwdata changing mid-transfer: ignored; the setup-phase captured values are used.
- Reset asserted mid-transfer: the transfer is discarded immediately and no write occurs.

Decomposition:
- apb_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH.
  - The FSM state enum apb_cmp_state_e {IDLE, WAIT, DONE}.
  - The address-decode function returning index and err.
- One sub-module, apb_cmp_fsm, holds the state, wait counter and pready/abort logic, and exports an accept strobe and a complete strobe.
- The register bank and read mux stay in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x04 with WAIT_STATES=1 -> pready high in the 2nd access cycle, pslverr=0. regs_o slice 1 = 0xDEADBEEF. wr_pulse_o=16'h0002 for one cycle.
- Read addr 0x04 -> prdata=0xDEADBEEF in the pready cycle and 0 otherwise. Read addr 0x20 (reg 8, RO) with ro_i slice 8=0x12345678 -> prdata=0x12345678.
- Write to 0x20 (RO), to 0x41 (misaligned), and to 0x40 (out of range) -> each gives pready=1 and pslverr=1, with registers and wr_pulse_o unchanged.
- WAIT_STATES=0, back-to-back writes to 0x00 then 0x08 -> each completes in 2 cycles with no idle gap, and both values land.
- Drop psel during WAIT on a write to 0x0C -> no pready, reg 3 stays 0, and the next transfer completes normally. Assert preset mid-transfer -> outputs go to 0 immediately.
- penable=1 with psel=1 straight from IDLE -> pready=1 and pslverr=1 on the next cycle, with no write.
